// File: rtl/scc_isa_pkg.sv
// SCC instruction-set field layout and fetch-stage types shared by the front end.
// The pre-decode helpers recognise only what fetch must act on early: B and HALT.
package scc_isa_pkg;

  localparam int unsigned LD1_HI      = 31;
  localparam int unsigned LD1_LO      = 30;
  localparam int unsigned SPECIAL_BIT = 29;
  localparam int unsigned LD2_HI      = 28;
  localparam int unsigned LD2_LO      = 25;
  localparam int unsigned IMM_HI      = 15;
  localparam int unsigned IMM_LO      = 0;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_MEM  = 2'b01;
  localparam logic [1:0] CLS_IMM  = 2'b10;
  localparam logic [1:0] CLS_CTRL = 2'b11;

  localparam logic [3:0] LD2_B     = 4'b0000;
  localparam logic [3:0] LD2_BCOND = 4'b0001;
  localparam logic [3:0] LD2_BR    = 4'b0010;

  localparam int unsigned HALT_BIT = 28;
  localparam int unsigned NOP_BIT  = 27;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic is_uncond_b(input logic [31:0] w);
    return (w[LD1_HI:LD1_LO] == CLS_CTRL) && !w[SPECIAL_BIT] &&
           (w[LD2_HI:LD2_LO] == LD2_B);
  endfunction

  // Control-class words outside the branch group; bit 28 set and bit 27 clear marks HALT.
  function automatic logic is_halt(input logic [31:0] w);
    logic [3:0] ld2;
    ld2 = w[LD2_HI:LD2_LO];
    return (w[LD1_HI:LD1_LO] == CLS_CTRL) &&
           (ld2 != LD2_B) && (ld2 != LD2_BCOND) && (ld2 != LD2_BR) &&
           w[HALT_BIT] && !w[NOP_BIT];
  endfunction

endpackage

// File: rtl/instr_queue.sv
// Small circular FIFO of fetched {pc, word} pairs with a one-entry lookahead port.
// Storage is not reset; consumers qualify head/next with count.
module instr_queue
  import scc_isa_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int QDEPTH = 4,
  parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [31:0]       push_word,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_pc,
  output logic [31:0]       head_word,
  output logic [31:0]       next_word,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(QDEPTH);

  logic [ADDR_W-1:0] pc_mem_q   [QDEPTH];
  logic [31:0]       word_mem_q [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  nxt_ptr;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // A push into a full queue lands on the slot being popped this same cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem_q[wr_ptr_q]   <= push_pc;
      word_mem_q[wr_ptr_q] <= push_word;
    end
  end

  always_comb begin
    nxt_ptr   = rd_ptr_q + PTR_W'(1);
    head_pc   = pc_mem_q[rd_ptr_q];
    head_word = word_mem_q[rd_ptr_q];
    next_word = word_mem_q[nxt_ptr];
    count     = count_q;
  end

endmodule

// File: rtl/instr_fetch.sv
// SCC fetch stage: one outstanding imem request, queue of fetched words toward ID,
// early redirect on unconditional B, stop at HALT, flush/restart from execute.
module instr_fetch
  import scc_isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       Instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [31:0]       Instruction_next,
  output logic              next_valid,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic              out_q, out_d;
  logic              req_q, req_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [CNT_W-1:0]  count, count_next;
  logic [ADDR_W-1:0] head_pc;
  logic [31:0]       head_word, next_word;
  logic              pop, push, resp_live, resp_halt, issue;
  logic [ADDR_W-1:0] resp_target;
  logic signed [15:0] b_imm;

  instr_queue #(
    .ADDR_W(ADDR_W),
    .QDEPTH(QDEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_pc  (pc_q),
    .push_word(imem_rdata),
    .pop      (pop),
    .head_pc  (head_pc),
    .head_word(head_word),
    .next_word(next_word),
    .count    (count)
  );

  // While a request is outstanding pc_q still holds its address, so it doubles as pc_of_req.
  always_comb begin
    id_valid    = (count != '0);
    pop         = id_valid && id_ready && !redirect_valid;
    resp_live   = imem_rvalid && out_q && (state_q == FETCH) && !redirect_valid;
    push        = resp_live;
    resp_halt   = resp_live && is_halt(imem_rdata);
    b_imm       = signed'(imem_rdata[IMM_HI:IMM_LO]);
    resp_target = pc_q + (is_uncond_b(imem_rdata) ? ADDR_W'(b_imm) : ADDR_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (out_q && !imem_rvalid) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH:   if (resp_halt) state_d = HALT;
        DRAIN:   if (imem_rvalid) state_d = FETCH;
        default: state_d = state_q;
      endcase
    end
  end

  // Issue credit counts the slot the new request will fill, so the queue cannot overflow.
  always_comb begin
    count_next = count - CNT_W'(pop) + CNT_W'(push);
    issue      = (state_q == FETCH) && !redirect_valid && !resp_halt &&
                 (!out_q || imem_rvalid) && (count_next < CNT_W'(QDEPTH));

    pc_d = pc_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (resp_live)  pc_d = resp_target;

    out_d = out_q;
    if (imem_rvalid) out_d = 1'b0;
    if (issue)       out_d = 1'b1;

    req_d  = issue;
    addr_d = issue ? pc_d : addr_q;

    halted_d = halted_q;
    if (redirect_valid)                    halted_d = 1'b0;
    else if (pop && is_halt(head_word))    halted_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      out_q    <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    imem_req         = req_q;
    imem_addr        = addr_q;
    Instruction      = id_valid ? head_word : '0;
    instr_pc         = id_valid ? head_pc : '0;
    next_valid       = (count >= CNT_W'(2));
    Instruction_next = next_valid ? next_word : '0;
    halted           = halted_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable instruction memory model.
module tb_instr_fetch;

  localparam int ADDR_W = 16;
  localparam int QDEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              id_valid;
  logic              id_ready = 1'b0;
  logic [31:0]       Instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic [31:0]       Instruction_next;
  logic              next_valid;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halted;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .Instruction(Instruction), .instr_pc(instr_pc),
    .Instruction_next(Instruction_next), .next_valid(next_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]       mem [256];
  int                lat = 1;
  logic              pend = 1'b0;
  int                cnt = 0;
  int                overlap = 0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [ADDR_W-1:0] raddr = '0;
  logic [ADDR_W-1:0] req_log[$];
  logic [ADDR_W-1:0] pop_pc_log[$];
  logic [31:0]       pop_word_log[$];

  // Memory model: responds lat cycles after seeing a request pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[paddr[7:0]];
          raddr       = paddr;
          pend        = 1'b0;
        end
      end
      if (imem_req) begin
        if (pend) overlap++;
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_addr;
        req_log.push_back(imem_addr);
      end
    end
  end

  // Records words ID accepts at the coming edge (inputs are settled by now).
  always @(negedge clk) begin
    #2;
    if (rst_n && id_valid && id_ready && !redirect_valid) begin
      pop_pc_log.push_back(instr_pc);
      pop_word_log.push_back(Instruction);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + 32'(i);
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc_log.delete();
    pop_word_log.delete();
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst_n = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    lat = l;
    tick(3);
    clear_logs();
    overlap = 0;
    id_ready = rdy;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    init_mem();
    do_reset(1, 1'b0);
    tick(12);
    rst_n = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_imem_req: got %0h want 0", imem_req); end
    n_vec++; if (imem_addr !== 16'h0) begin n_err++; $display("FAIL reset_imem_addr: got %0h want 0", imem_addr); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid: got %0h want 0", id_valid); end
    n_vec++; if (Instruction !== 32'h0) begin n_err++; $display("FAIL reset_instruction: got %0h want 0", Instruction); end
    n_vec++; if (instr_pc !== 16'h0) begin n_err++; $display("FAIL reset_instr_pc: got %0h want 0", instr_pc); end
    n_vec++; if (Instruction_next !== 32'h0) begin n_err++; $display("FAIL reset_instr_next: got %0h want 0", Instruction_next); end
    n_vec++; if (next_valid !== 1'b0) begin n_err++; $display("FAIL reset_next_valid: got %0h want 0", next_valid); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %0h want 0", halted); end
  endtask

  task automatic test_straight_line();
    init_mem();
    do_reset(1, 1'b1);
    tick(14);
    n_vec++;
    if (req_log.size() < 4 || pop_pc_log.size() < 4) begin
      n_err++; $display("FAIL straight_counts: got %0d reqs %0d pops want >=4 each", req_log.size(), pop_pc_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (req_log[i] !== 16'(i)) begin n_err++; $display("FAIL straight_req%0d: got %0h want %0h", i, req_log[i], i); end
        n_vec++; if (pop_pc_log[i] !== 16'(i)) begin n_err++; $display("FAIL straight_pc%0d: got %0h want %0h", i, pop_pc_log[i], i); end
        n_vec++; if (pop_word_log[i] !== 32'h1000 + 32'(i)) begin n_err++; $display("FAIL straight_word%0d: got %0h want %0h", i, pop_word_log[i], 32'h1000 + 32'(i)); end
      end
    end
  endtask

  task automatic test_fill_and_lookahead();
    init_mem();
    do_reset(1, 1'b0);
    tick(20);
    n_vec++; if (req_log.size() != 4) begin n_err++; $display("FAIL fill_req_count: got %0d want 4", req_log.size()); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL fill_req_idle: got %0h want 0", imem_req); end
    n_vec++; if (next_valid !== 1'b1) begin n_err++; $display("FAIL fill_next_valid: got %0h want 1", next_valid); end
    n_vec++; if (instr_pc !== 16'h0) begin n_err++; $display("FAIL fill_head_pc: got %0h want 0", instr_pc); end
    n_vec++; if (Instruction !== 32'h1000) begin n_err++; $display("FAIL fill_head_word: got %0h want 1000", Instruction); end
    n_vec++; if (Instruction_next !== 32'h1001) begin n_err++; $display("FAIL fill_next_word: got %0h want 1001", Instruction_next); end
    id_ready = 1'b1;
    tick(1);
    id_ready = 1'b0;
    tick(6);
    n_vec++; if (req_log.size() != 5) begin n_err++; $display("FAIL pop_req_count: got %0d want 5", req_log.size()); end
    else begin
      n_vec++; if (req_log[4] !== 16'h4) begin n_err++; $display("FAIL pop_req_addr: got %0h want 4", req_log[4]); end
    end
    n_vec++; if (instr_pc !== 16'h1) begin n_err++; $display("FAIL pop_head_pc: got %0h want 1", instr_pc); end
    n_vec++; if (Instruction_next !== 32'h1002) begin n_err++; $display("FAIL pop_next_word: got %0h want 1002", Instruction_next); end
  endtask

  task automatic test_branch();
    logic bad;
    init_mem();
    mem[5] = 32'hC000_FFFE;
    do_reset(1, 1'b1);
    tick(26);
    n_vec++;
    if (req_log.size() < 8) begin
      n_err++; $display("FAIL branch_req_count: got %0d want >=8", req_log.size());
    end else begin
      n_vec++; if (req_log[6] !== 16'h3) begin n_err++; $display("FAIL branch_target: got %0h want 3", req_log[6]); end
      n_vec++; if (req_log[7] !== 16'h4) begin n_err++; $display("FAIL branch_after: got %0h want 4", req_log[7]); end
    end
    bad = 1'b0;
    foreach (req_log[i]) if (req_log[i] == 16'h6) bad = 1'b1;
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL branch_fallthrough: got req to 6 want none"); end
    n_vec++;
    if (pop_pc_log.size() < 7) begin n_err++; $display("FAIL branch_pops: got %0d want >=7", pop_pc_log.size()); end
    else if (pop_pc_log[6] !== 16'h3) begin n_err++; $display("FAIL branch_pop_pc: got %0h want 3", pop_pc_log[6]); end
  endtask

  task automatic test_redirect_outstanding();
    int waited;
    init_mem();
    do_reset(3, 1'b0);
    waited = 0;
    while (!(imem_req && imem_addr == 16'h1) && waited < 40) begin
      tick(1);
      waited++;
    end
    n_vec++;
    if (waited >= 40) begin
      n_err++; $display("FAIL redir_wait: got no request to 1 want one within 40 cycles");
      return;
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    clear_logs();
    tick(1);
    redirect_valid = 1'b0;
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got id_valid %0h want 0", id_valid); end
    id_ready = 1'b1;
    tick(20);
    n_vec++; if (overlap != 0) begin n_err++; $display("FAIL redir_overlap: got %0d overlapping requests want 0", overlap); end
    n_vec++;
    if (req_log.size() < 1) begin n_err++; $display("FAIL redir_req: got no request want 40"); end
    else if (req_log[0] !== 16'h0040) begin n_err++; $display("FAIL redir_req: got %0h want 40", req_log[0]); end
    n_vec++;
    if (pop_pc_log.size() < 1) begin n_err++; $display("FAIL redir_pop: got no word want pc 40"); end
    else begin
      if (pop_pc_log[0] !== 16'h0040) begin n_err++; $display("FAIL redir_pop: got pc %0h want 40", pop_pc_log[0]); end
      n_vec++; if (pop_word_log[0] !== 32'h1040) begin n_err++; $display("FAIL redir_word: got %0h want 1040", pop_word_log[0]); end
    end
  endtask

  task automatic test_redirect_same_cycle();
    int waited;
    logic bad;
    init_mem();
    do_reset(1, 1'b1);
    waited = 0;
    while (!(imem_rvalid && raddr == 16'h2) && waited < 40) begin
      tick(1);
      waited++;
    end
    n_vec++;
    if (waited >= 40) begin
      n_err++; $display("FAIL same_wait: got no response for 2 want one within 40 cycles");
      return;
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0020;
    clear_logs();
    tick(1);
    redirect_valid = 1'b0;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL same_no_early_req: got %0h want 0", imem_req); end
    tick(14);
    n_vec++;
    if (req_log.size() < 1) begin n_err++; $display("FAIL same_req: got no request want 20"); end
    else if (req_log[0] !== 16'h0020) begin n_err++; $display("FAIL same_req: got %0h want 20", req_log[0]); end
    n_vec++;
    if (pop_pc_log.size() < 1) begin n_err++; $display("FAIL same_pop: got no word want pc 20"); end
    else if (pop_pc_log[0] !== 16'h0020) begin n_err++; $display("FAIL same_pop: got pc %0h want 20", pop_pc_log[0]); end
    bad = 1'b0;
    foreach (pop_pc_log[i]) if (pop_pc_log[i] == 16'h2) bad = 1'b1;
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL same_dropped: got word pc 2 presented want none"); end
  endtask

  task automatic test_halt();
    logic seen, checked, bad;
    init_mem();
    mem[2] = 32'hD000_0000;
    do_reset(1, 1'b1);
    seen = 1'b0;
    checked = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (seen && !checked) begin
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set: got %0h want 1", halted); end
        checked = 1'b1;
      end
      if (!seen && id_valid && id_ready && instr_pc == 16'h2) begin
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_early: got %0h want 0", halted); end
        seen = 1'b1;
      end
    end
    n_vec++; if (checked !== 1'b1) begin n_err++; $display("FAIL halt_accept: got no accept of pc 2 want one within 30 cycles"); end
    n_vec++; if (req_log.size() != 3) begin n_err++; $display("FAIL halt_req_count: got %0d want 3", req_log.size()); end
    bad = 1'b0;
    foreach (req_log[i]) if (req_log[i] == 16'h3) bad = 1'b1;
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL halt_no_req3: got req to 3 want none"); end
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %0h want 1", halted); end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    clear_logs();
    tick(1);
    redirect_valid = 1'b0;
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_clear: got %0h want 0", halted); end
    tick(10);
    n_vec++;
    if (req_log.size() < 1) begin n_err++; $display("FAIL halt_resume: got no request want 0"); end
    else if (req_log[0] !== 16'h0000) begin n_err++; $display("FAIL halt_resume: got %0h want 0", req_log[0]); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_fill_and_lookahead();
    test_branch();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the SCC pipeline; the producer end of the decoder's Instruction/Instruction_next interface.
- Issues word-addressed requests to instruction memory and buffers returned words with their PCs in a small queue.
- Presents the head word plus one-word lookahead to ID, pre-decodes unconditional B to redirect fetch early, and stops fetching at HALT.
- Accepts flush/redirect from execute.

Parameters:
- ADDR_W, 16, instruction word address width; PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0, first fetch address after reset.
- QDEPTH, 4, instruction queue entries (power of two, at least 2).

Ports:
- clk  in  1  single clock; everything is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  ADDR_W  word address; valid while imem_req=1.
- imem_rvalid  in  1  response strobe; exactly one per request, at least 1 cycle after it.
- imem_rdata  in  32  instruction word; valid with imem_rvalid.
- id_valid  out  1  Instruction holds a valid word.
- id_ready  in  1  ID accepts the head word this cycle.
- Instruction  out  32  head word.
- instr_pc  out  ADDR_W  PC of the head word.
- Instruction_next  out  32  second queue entry; 0 when next_valid=0.
- next_valid  out  1  queue count is at least 2.
- redirect_valid  in  1  flush and restart from redirect_pc.
- redirect_pc  in  ADDR_W  restart address.
- halted  out  1  a HALT word has been accepted by ID.

Behaviour:
- Reset: pc=RESET_PC; queue empty; state=FETCH. All outputs are 0 during reset (imem_req, imem_addr, id_valid, Instruction, instr_pc, Instruction_next, next_valid, halted).
- Memory interface: at most one request outstanding (flag out).
- Issue condition: state=FETCH, out=0 (or the response arrives this cycle), count+out < QDEPTH after this cycle's pop, and redirect_valid=0.
- On issue: imem_addr=pc, and out is set.
- States:
  - FETCH: issuing permitted.
  - DRAIN: one stale response pending; it is discarded on arrival, then state returns to FETCH.
  - HALT: no issues.
- Response (not stale, no redirect): push {pc_of_req, imem_rdata}. Next pc:
  - pre-decoded unconditional B ([31:30]=11, [29]=0, [28:25]=0000): pc = pc_of_req + sext(rdata[15:0]).
  - otherwise: pc = pc_of_req + 1.
  - A request may issue in the same cycle using the new pc. With 1-cycle memory latency and ID always ready, throughput is 1 word every 2 cycles.
- HALT pre-decode: [31:30]=11, [28:25] not in {0000,0001,0010}, [27]=0, [28]=1. The word is pushed, state -> HALT, no further issues. halted=1 the cycle after ID accepts that word, and it stays set until reset or redirect.
- Pop: when id_valid & id_ready. Push and pop in the same cycle are legal, including when the queue is full. The issue-credit check makes overflow impossible.
- Redirect (highest priority, any state):
  - Queue flushed that cycle; id_valid=0 next cycle; pc=redirect_pc; halted cleared.
  - If a request is outstanding and its response does not arrive in the redirect cycle: state -> DRAIN.
  - If the response arrives in the redirect cycle: it is dropped, state -> FETCH.
  - First new request no earlier than the cycle after the redirect.
- Redirect during DRAIN: pc updated; stays in DRAIN.
- Outputs are registered or driven from queue storage; no combinational path from imem_rdata to Instruction.
- PC increment and branch target wrap modulo 2^ADDR_W with no error indication.
- Queue empty: id_valid=0, and Instruction/instr_pc hold 0.

Decomposition:
- scc_isa_pkg holds:
  - field position constants (1LD [31:30], special [29], 2LD [28:25], imm [15:0]);
  - 1LD class codes;
  - the 2LD codes for B, B.cond, BR;
  - the NOP/HALT bit positions;
  - fetch_state_t enum {FETCH, DRAIN, HALT}.
- Sub-module instr_queue: parameterised FIFO of {pc, word}. It exposes head, head+1, count, push and pop.

Test Plan:
- Reset, 1-cycle memory with straight-line words at 0..3, id_ready=1 -> requests to 0,1,2,3 in order; instr_pc sequence 0,1,2,3; Instruction_next at pc0 equals the word at 1 once count=2.
- Word at 5 is B with imm=0xFFFE -> next imem_addr=3; no request to 6.
- id_ready=0 with QDEPTH=4 -> exactly 4 requests, then imem_req stays 0; one pop -> one new request.
- 3-cycle memory latency; redirect to 0x40 while a request is outstanding -> queue empties; the stale response is discarded; next imem_addr=0x40 and the following id_valid word has instr_pc=0x40.
- Redirect in the same cycle as imem_rvalid -> that word is never presented; next imem_addr equals redirect_pc.
- HALT word at 2 -> no request to 3; halted=1 one cycle after pc 2 is accepted; a later redirect to 0 clears halted and fetching resumes at 0.
